mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Main-memory controller sitting directly downstream of the icache and dcache miss/writeback interfaces.
- Arbitrates one outstanding block request at a time, icache with fixed priority.
- Models main memory as an internal block array with fixed access latency.
- Returns a one-cycle response pulse with block data to the requesting cache.

Parameters:
- BLOCK_DATA_WIDTH, 64, bits per cache block (block_data_t width).
- BLOCK_ADDR_WIDTH, 29, bits of block address (main_mem_block_addr_t width).
- MEM_N_BLOCKS, 1024, blocks in the backing array (power of two).
- MEM_LATENCY, 10, cycles from request acceptance to response; must be >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- icache_req_valid  in  1  icache read request
- icache_req_block_addr  in  BLOCK_ADDR_WIDTH  icache block address
- icache_req_ready  out  1  controller accepts icache request
- icache_resp_valid  out  1  icache response pulse
- icache_resp_block_data  out  BLOCK_DATA_WIDTH  icache read data
- dcache_req_valid  in  1  dcache request
- dcache_req_type  in  1  req_type_t: 0 read, 1 write
- dcache_req_block_addr  in  BLOCK_ADDR_WIDTH  dcache block address
- dcache_req_block_data  in  BLOCK_DATA_WIDTH  write data, ignored on reads
- dcache_req_ready  out  1  controller accepts dcache request
- dcache_resp_valid  out  1  dcache response pulse, read data or write ack
- dcache_resp_block_data  out  BLOCK_DATA_WIDTH  dcache read data or echoed write data

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high.
- Reset: state=IDLE, counter=0, all resp_valid=0, resp data=0, latched request cleared. The memory array is not reset and keeps its contents.
- FSM states:
  - IDLE: icache_req_ready=1; dcache_req_ready=~icache_req_valid.
  - BUSY and RESP: both readies=0.
- Acceptance (IDLE only), in priority order:
  - If icache_req_valid, latch {src=I, type=read, addr}; icache always wins a same-cycle conflict.
  - Else if dcache_req_valid, latch {src=D, type, addr, data}.
  - On acceptance: counter<=MEM_LATENCY-2, go to BUSY.
- BUSY:
  - Decrement counter each cycle.
  - At counter==0, the transition edge to RESP does the memory access.
  - Write: mem[addr mod MEM_N_BLOCKS]<=data.
  - Read: latch resp data<=mem[addr mod MEM_N_BLOCKS].
- RESP (exactly one cycle):
  - Assert resp_valid for the latched src only; the other resp_valid stays 0.
  - Write ack data = the written block.
  - Next state IDLE.
- Latency: if the request is accepted in cycle T, resp_valid is high in cycle T+MEM_LATENCY. The next request can be accepted no earlier than cycle T+MEM_LATENCY+1.
- Data path:
  - resp data registers hold their value outside RESP; only resp_valid qualifies them.
  - Inputs are sampled only at the acceptance edge; changes during BUSY are ignored.
- Ordering: a write commits at the RESP entry edge, so a later read to the same block returns the new data.
- Addressing: index = low log2(MEM_N_BLOCKS) bits of the block address; upper bits are ignored (aliasing).
- Reset mid-transaction: immediate return to IDLE. No response is produced, and a pending write is dropped if it has not reached the commit edge.
- Requests are never queued: a valid that is not accepted must be held by the requester until ready.

Test Plan:
1. Reset, then dcache write addr=0x5, data=0xDEADBEEF_CAFEF00D accepted at cycle 2 -> dcache_resp_valid only in cycle 12 with that data; icache_resp_valid stays 0.
2. Then dcache read addr=0x5 -> dcache_resp_valid 10 cycles after acceptance, data 0xDEADBEEF_CAFEF00D.
3. icache and dcache valid in the same IDLE cycle -> icache accepted (dcache_req_ready=0); after the icache response, dcache is accepted the cycle after RESP, and its response arrives MEM_LATENCY later.
4. Write addr=0x405 with MEM_N_BLOCKS=1024, then read addr=0x5 -> aliased data returned.
5. Accept a write, assert rst at counter mid-count -> outputs 0, state IDLE, a later read of that block returns the old contents.
6. Back-to-back requests held valid continuously -> acceptances spaced exactly MEM_LATENCY+1 cycles apart; ready low throughout BUSY/RESP.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: main-memory controller below the icache and dcache.
// Serves one block request at a time (icache has fixed priority) against an
// internal block array with a fixed latency, then pulses a one-cycle response.
//
// Ports:
//   clk, rst                    clock; asynchronous active-high reset
//   icache_req_valid/_block_addr/_ready      icache read request handshake
//   icache_resp_valid/_block_data            icache response pulse + data
//   dcache_req_valid/_type/_block_addr/_block_data/_ready
//                                            dcache read/write request
//   dcache_resp_valid/_block_data            dcache response pulse + data
//                                            (read data or echoed write data)

package mem_ctrl_pkg;
  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_type_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } src_t;
endpackage

module mem_ctrl #(
  parameter int unsigned BLOCK_DATA_WIDTH = 64,
  parameter int unsigned BLOCK_ADDR_WIDTH = 29,
  parameter int unsigned MEM_N_BLOCKS     = 1024,
  parameter int unsigned MEM_LATENCY      = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        icache_req_valid,
  input  logic [BLOCK_ADDR_WIDTH-1:0] icache_req_block_addr,
  output logic                        icache_req_ready,
  output logic                        icache_resp_valid,
  output logic [BLOCK_DATA_WIDTH-1:0] icache_resp_block_data,
  input  logic                        dcache_req_valid,
  input  logic                        dcache_req_type,
  input  logic [BLOCK_ADDR_WIDTH-1:0] dcache_req_block_addr,
  input  logic [BLOCK_DATA_WIDTH-1:0] dcache_req_block_data,
  output logic                        dcache_req_ready,
  output logic                        dcache_resp_valid,
  output logic [BLOCK_DATA_WIDTH-1:0] dcache_resp_block_data
);
  import mem_ctrl_pkg::*;

  localparam int unsigned IDX_W = $clog2(MEM_N_BLOCKS);
  // Counter only ever holds MEM_LATENCY-2 down to 0.
  localparam int unsigned CNT_W = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY - 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Latched request; only the array index of the address is kept.
  typedef struct packed {
    src_t                        src;
    req_type_t                   rtype;
    logic [IDX_W-1:0]            idx;
    logic [BLOCK_DATA_WIDTH-1:0] data;
  } req_t;

  state_t                      state, state_d;
  logic [CNT_W-1:0]            cnt, cnt_d;
  req_t                        req, req_d;
  logic                        icache_resp_valid_d, dcache_resp_valid_d;
  logic [BLOCK_DATA_WIDTH-1:0] icache_resp_block_data_d, dcache_resp_block_data_d;
  logic                        mem_we;
  logic [BLOCK_DATA_WIDTH-1:0] access_data;

  logic [BLOCK_DATA_WIDTH-1:0] mem [MEM_N_BLOCKS];

  // Upper address bits alias onto the same block and are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{icache_req_block_addr[BLOCK_ADDR_WIDTH-1:IDX_W],
                              dcache_req_block_addr[BLOCK_ADDR_WIDTH-1:IDX_W]};

  // State, counter, latched request and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                  <= IDLE;
      cnt                    <= '0;
      req                    <= '0;
      icache_resp_valid      <= 1'b0;
      dcache_resp_valid      <= 1'b0;
      icache_resp_block_data <= '0;
      dcache_resp_block_data <= '0;
    end else begin
      state                  <= state_d;
      cnt                    <= cnt_d;
      req                    <= req_d;
      icache_resp_valid      <= icache_resp_valid_d;
      dcache_resp_valid      <= dcache_resp_valid_d;
      icache_resp_block_data <= icache_resp_block_data_d;
      dcache_resp_block_data <= dcache_resp_block_data_d;
    end
  end

  // Backing array: not reset; written only on the BUSY->RESP edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[req.idx] <= req.data;
    end
  end

  // Next-state, acceptance and memory access.
  always_comb begin
    state_d                  = state;
    cnt_d                    = cnt;
    req_d                    = req;
    icache_resp_valid_d      = 1'b0;
    dcache_resp_valid_d      = 1'b0;
    icache_resp_block_data_d = icache_resp_block_data;
    dcache_resp_block_data_d = dcache_resp_block_data;
    mem_we                   = 1'b0;
    access_data              = '0;
    icache_req_ready         = 1'b0;
    dcache_req_ready         = 1'b0;

    case (state)
      IDLE: begin
        icache_req_ready = 1'b1;
        dcache_req_ready = ~icache_req_valid;
        if (icache_req_valid) begin
          req_d.src   = SRC_I;
          req_d.rtype = REQ_READ;
          req_d.idx   = icache_req_block_addr[IDX_W-1:0];
          req_d.data  = '0;
          cnt_d       = CNT_W'(MEM_LATENCY - 2);
          state_d     = BUSY;
        end else if (dcache_req_valid) begin
          req_d.src   = SRC_D;
          req_d.rtype = req_type_t'(dcache_req_type);
          req_d.idx   = dcache_req_block_addr[IDX_W-1:0];
          req_d.data  = dcache_req_block_data;
          cnt_d       = CNT_W'(MEM_LATENCY - 2);
          state_d     = BUSY;
        end
      end

      BUSY: begin
        if (cnt == '0) begin
          state_d = RESP;
          if (req.rtype == REQ_WRITE) begin
            mem_we      = 1'b1;
            access_data = req.data;
          end else begin
            access_data = mem[req.idx];
          end
          // Only the requesting side's response registers change.
          if (req.src == SRC_I) begin
            icache_resp_valid_d      = 1'b1;
            icache_resp_block_data_d = access_data;
          end else begin
            dcache_resp_valid_d      = 1'b1;
            dcache_resp_block_data_d = access_data;
          end
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: requests are issued against a model of the
// arbitration rules and a flat block memory; a monitor checks every response.
module tb_mem_ctrl;
  localparam int unsigned DW = 64;
  localparam int unsigned AW = 29;
  localparam int N = 1024;
  localparam int L = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          icache_req_valid = 1'b0;
  logic [AW-1:0] icache_req_block_addr = '0;
  logic          icache_req_ready;
  logic          icache_resp_valid;
  logic [DW-1:0] icache_resp_block_data;
  logic          dcache_req_valid = 1'b0;
  logic          dcache_req_type = 1'b0;
  logic [AW-1:0] dcache_req_block_addr = '0;
  logic [DW-1:0] dcache_req_block_data = '0;
  logic          dcache_req_ready;
  logic          dcache_resp_valid;
  logic [DW-1:0] dcache_resp_block_data;

  mem_ctrl #(
    .BLOCK_DATA_WIDTH(DW), .BLOCK_ADDR_WIDTH(AW),
    .MEM_N_BLOCKS(N), .MEM_LATENCY(L)
  ) dut (
    .clk(clk), .rst(rst),
    .icache_req_valid(icache_req_valid),
    .icache_req_block_addr(icache_req_block_addr),
    .icache_req_ready(icache_req_ready),
    .icache_resp_valid(icache_resp_valid),
    .icache_resp_block_data(icache_resp_block_data),
    .dcache_req_valid(dcache_req_valid),
    .dcache_req_type(dcache_req_type),
    .dcache_req_block_addr(dcache_req_block_addr),
    .dcache_req_block_data(dcache_req_block_data),
    .dcache_req_ready(dcache_req_ready),
    .dcache_resp_valid(dcache_resp_valid),
    .dcache_resp_block_data(dcache_resp_block_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          src_d;
    bit          is_write;
    int          idx;
    logic [63:0] data;
    bit          chk;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [63:0] mem_model [N];
  bit          known [N];
  int          n_checks = 0;
  int          n_pass = 0;
  bit          started = 0;
  int          busy_until = -1;   // last cycle of the transaction in flight

  // Pending requests, held by the requester until accepted.
  bit          pi_valid = 0;
  logic [AW-1:0] pi_addr = '0;
  bit          pd_valid = 0;
  bit          pd_write = 0;
  logic [AW-1:0] pd_addr = '0;
  logic [63:0] pd_data = '0;

  bit          track_acc = 0;
  int          acc_cycles[$];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Response monitor / scoreboard.
  always @(negedge clk) begin
    if (started && !rst) begin
      if (icache_resp_valid || dcache_resp_valid) begin
        exp_t e;
        check("resp_exclusive", 64'(icache_resp_valid & dcache_resp_valid), 64'd0);
        if (q.size() == 0) begin
          check("unexpected_resp", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check("resp_src", 64'(dcache_resp_valid), 64'(e.src_d));
          check("resp_cycle", 64'(cyc), 64'(e.due));
          if (e.chk)
            check("resp_data", e.src_d ? dcache_resp_block_data : icache_resp_block_data, e.data);
          if (e.is_write) begin
            mem_model[e.idx] = e.data;
            known[e.idx] = 1;
          end
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        check("missing_resp", 64'd0, 64'd1);
        void'(q.pop_front());
      end
    end
  end

  // One cycle of driving: present pending requests, check readies, model acceptance.
  task automatic step();
    bit   idle;
    exp_t e;
    icache_req_valid      = pi_valid;
    icache_req_block_addr = pi_addr;
    dcache_req_valid      = pd_valid;
    dcache_req_type       = pd_write;
    dcache_req_block_addr = pd_addr;
    dcache_req_block_data = pd_data;
    #1;
    idle = (cyc > busy_until);
    check("icache_req_ready", 64'(icache_req_ready), 64'(idle));
    check("dcache_req_ready", 64'(dcache_req_ready), 64'(idle && !pi_valid));
    if (track_acc && ((icache_req_ready && icache_req_valid) ||
                      (dcache_req_ready && dcache_req_valid)))
      acc_cycles.push_back(cyc);
    if (idle && pi_valid) begin
      e.src_d = 0; e.is_write = 0; e.idx = int'(pi_addr) % N;
      e.data = mem_model[e.idx]; e.chk = known[e.idx]; e.due = cyc + L;
      q.push_back(e);
      busy_until = cyc + L;
      pi_valid = 0;
    end else if (idle && pd_valid) begin
      e.src_d = 1; e.is_write = pd_write; e.idx = int'(pd_addr) % N;
      e.data = pd_write ? pd_data : mem_model[e.idx];
      e.chk = pd_write || known[e.idx]; e.due = cyc + L;
      q.push_back(e);
      busy_until = cyc + L;
      pd_valid = 0;
    end
    @(negedge clk);
  endtask

  task automatic issue_d(bit wr, logic [AW-1:0] addr, logic [63:0] data);
    pd_valid = 1; pd_write = wr; pd_addr = addr; pd_data = data;
  endtask

  task automatic issue_i(logic [AW-1:0] addr);
    pi_valid = 1; pi_addr = addr;
  endtask

  task automatic drain(int max);
    int n = 0;
    while ((pi_valid || pd_valid || q.size() != 0) && n < max) begin
      step();
      n++;
    end
    step();  // let the last response pop before the next phase
    if (pi_valid || pd_valid || q.size() != 0) check("drain_timeout", 64'd1, 64'd0);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = AW'($urandom) & ~AW'(N - 1);
    return a | AW'($urandom_range(0, 15));
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("rst_icache_resp_valid", 64'(icache_resp_valid), 64'd0);
    check("rst_dcache_resp_valid", 64'(dcache_resp_valid), 64'd0);
    check("rst_icache_resp_data", icache_resp_block_data, 64'd0);
    check("rst_dcache_resp_data", dcache_resp_block_data, 64'd0);
    @(negedge clk);
    rst = 0;
    started = 1;

    // Write then read back the same block.
    issue_d(1, 29'h5, 64'hDEADBEEF_CAFEF00D);
    drain(40);
    issue_d(0, 29'h5, '0);
    drain(40);

    // Same-cycle conflict: icache first, dcache the cycle after RESP.
    issue_i(29'h5);
    issue_d(1, 29'h7, 64'h0123_4567_89AB_CDEF);
    drain(60);

    // Aliasing: 0x405 and 0x5 map to the same block.
    issue_d(1, 29'h405, 64'hA5A5_0000_5A5A_1111);
    drain(40);
    issue_d(0, 29'h5, '0);
    drain(40);
    issue_i(29'h1FFF_FC05);
    drain(40);

    // Reset while a write is counting down: write must be dropped.
    issue_d(1, 29'h5, 64'h1111_2222_3333_4444);
    for (int i = 0; i < 20 && pd_valid; i++) step();
    repeat (4) step();
    rst = 1;
    icache_req_valid = 0; dcache_req_valid = 0;
    pi_valid = 0; pd_valid = 0;
    q.delete();
    #1;
    check("midrst_icache_resp_valid", 64'(icache_resp_valid), 64'd0);
    check("midrst_dcache_resp_valid", 64'(dcache_resp_valid), 64'd0);
    check("midrst_dcache_resp_data", dcache_resp_block_data, 64'd0);
    check("midrst_icache_req_ready", 64'(icache_req_ready), 64'd1);
    check("midrst_dcache_req_ready", 64'(dcache_req_ready), 64'd1);
    busy_until = -1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    issue_d(0, 29'h5, '0);
    drain(40);

    // Continuously held requests: acceptances exactly L+1 apart.
    track_acc = 1;
    for (int i = 0; i < 6 * (L + 1); i++) begin
      if (!pd_valid) issue_d(1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom});
      step();
    end
    track_acc = 0;
    pd_valid = 0;
    drain(40);
    check("held_accept_count", 64'(acc_cycles.size()), 64'd6);
    for (int i = 1; i < acc_cycles.size(); i++)
      check("held_accept_spacing", 64'(acc_cycles[i] - acc_cycles[i-1]), 64'(L + 1));

    // Random traffic from both caches.
    for (int i = 0; i < 600; i++) begin
      if (!pi_valid && $urandom_range(0, 4) == 0) issue_i(rand_addr());
      if (!pd_valid && $urandom_range(0, 2) == 0)
        issue_d(1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom});
      step();
    end
    drain(80);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
